// File: rtl/fp16_div_seq.sv
`default_nettype none
// ============================================================================
//  Module      : fp16_div_seq
//  Description : Multi-cycle IEEE-754 binary16 divider. A restoring mantissa
//                divider produces one quotient bit per cycle, and the result
//                is rounded to nearest-even. Valid/ready handshakes are used
//                on both the input and output sides.
//  Revision    : 1.0  initial release
// ============================================================================
module fp16_div_seq #(
    parameter logic [6:0]  BIAS = 7'd15,
    parameter logic [15:0] QNAN = 16'h7E00
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] q
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DIV   = 2'd1,
        ROUND = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [3:0] c_LAST_ITER = 4'd13;

    state_t      r_state;
    state_t      w_state_nxt;
    logic        r_load;
    logic [3:0]  r_cnt;
    logic [15:0] r_a;
    logic [15:0] r_b;
    logic [15:0] r_q;
    logic [11:0] r_rem;
    logic [13:0] r_quo;

    // Operand classification; subnormals are treated as signed zero
    logic [4:0] w_ea, w_eb;
    logic       w_a_zero, w_b_zero, w_a_inf, w_b_inf, w_a_nan, w_b_nan;
    logic       w_sign;

    assign w_ea     = r_a[14:10];
    assign w_eb     = r_b[14:10];
    assign w_a_zero = (w_ea == 5'd0);
    assign w_b_zero = (w_eb == 5'd0);
    assign w_a_inf  = (w_ea == 5'h1F) && (r_a[9:0] == 10'd0);
    assign w_b_inf  = (w_eb == 5'h1F) && (r_b[9:0] == 10'd0);
    assign w_a_nan  = (w_ea == 5'h1F) && (r_a[9:0] != 10'd0);
    assign w_b_nan  = (w_eb == 5'h1F) && (r_b[9:0] != 10'd0);
    assign w_sign   = r_a[15] ^ r_b[15];

    logic        w_special;
    logic [15:0] w_special_res;

    always_comb begin
        w_special     = 1'b1;
        w_special_res = QNAN;
        if (w_a_nan || w_b_nan || (w_a_zero && w_b_zero) || (w_a_inf && w_b_inf)) begin
            w_special_res = QNAN;
        end else if (w_b_zero || w_a_inf) begin
            w_special_res = {w_sign, 15'h7C00};
        end else if (w_a_zero || w_b_inf) begin
            w_special_res = {w_sign, 15'h0000};
        end else begin
            w_special = 1'b0;
        end
    end

    // Restoring divider step
    logic [11:0] w_mb;
    logic        w_ge;
    logic [11:0] w_rem_sub;

    assign w_mb      = {2'b01, r_b[9:0]};
    assign w_ge      = (r_rem >= w_mb);
    assign w_rem_sub = w_ge ? (r_rem - w_mb) : r_rem;

    // Normalise and round to nearest-even
    logic [6:0]  w_e_base, w_e_norm, w_e_rnd;
    logic [10:0] w_man;
    logic        w_g, w_s, w_inc;
    logic [11:0] w_man_rnd;
    logic [9:0]  w_frac;
    logic [15:0] w_result;

    assign w_e_base  = {2'b00, w_ea} - {2'b00, w_eb} + BIAS;
    assign w_man     = r_quo[13] ? r_quo[13:3] : r_quo[12:2];
    assign w_g       = r_quo[13] ? r_quo[2] : r_quo[1];
    assign w_s       = (r_quo[13] ? (|r_quo[1:0]) : r_quo[0]) | (r_rem != 12'd0);
    assign w_e_norm  = r_quo[13] ? w_e_base : (w_e_base - 7'd1);
    assign w_inc     = w_g & (w_s | w_man[0]);
    assign w_man_rnd = {1'b0, w_man} + {11'd0, w_inc};
    assign w_e_rnd   = w_e_norm + {6'd0, w_man_rnd[11]};
    assign w_frac    = w_man_rnd[11] ? w_man_rnd[10:1] : w_man_rnd[9:0];

    always_comb begin
        w_result = {w_sign, w_e_rnd[4:0], w_frac};
        if (w_special) begin
            w_result = w_special_res;
        end else if ($signed(w_e_rnd) >= 7'sd31) begin
            w_result = {w_sign, 15'h7C00};
        end else if ($signed(w_e_rnd) <= 7'sd0) begin
            w_result = {w_sign, 15'h0000};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (in_valid) w_state_nxt = DIV;
            DIV:     if (!r_load && (r_cnt == c_LAST_ITER)) w_state_nxt = ROUND;
            ROUND:   w_state_nxt = DONE;
            DONE:    if (out_ready) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // The first DIV cycle seeds the remainder; the next 14 each retire one quotient bit
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a    <= 16'd0;
            r_b    <= 16'd0;
            r_q    <= 16'd0;
            r_rem  <= 12'd0;
            r_quo  <= 14'd0;
            r_cnt  <= 4'd0;
            r_load <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_a    <= a;
                        r_b    <= b;
                        r_cnt  <= 4'd0;
                        r_load <= 1'b1;
                    end
                end
                DIV: begin
                    if (r_load) begin
                        r_rem  <= {2'b01, r_a[9:0]};
                        r_quo  <= 14'd0;
                        r_load <= 1'b0;
                    end else begin
                        r_rem <= w_rem_sub << 1;
                        r_quo <= {r_quo[12:0], w_ge};
                        r_cnt <= r_cnt + 4'd1;
                    end
                end
                ROUND: r_q <= w_result;
                default: ;
            endcase
        end
    end

    assign in_ready  = (r_state == IDLE);
    assign out_valid = (r_state == DONE);
    assign q         = r_q;

endmodule
`default_nettype wire

// File: tb/tb_fp16_div_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fp16_div_seq
//  Description : Scoreboard bench for fp16_div_seq with an exact-rational
//                reference model of fp16 division.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_fp16_div_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a;
    logic [15:0] b;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] q;

    always #5 clk = ~clk;

    fp16_div_seq dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .q         (q)
    );

    typedef struct {
        logic [15:0] v;
        int          acc;
    } exp_t;

    exp_t        sb[$];
    int          total = 0;
    int          bad   = 0;
    int          cyc   = 0;
    logic        hold_off = 1'b0;
    logic        seen = 1'b0;
    logic [15:0] held;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", nm, act, req, $time);
        end
    endtask

    // Reference: exact quotient of the significands, rounded nearest-even
    function automatic logic [15:0] model(input logic [15:0] x, input logic [15:0] y);
        logic s;
        int   ex, ey, fx, fy, ma, mb, e, num, m, r;
        bit   zx, zy, ix, iy, nx, ny;
        s  = x[15] ^ y[15];
        ex = int'(x[14:10]); ey = int'(y[14:10]);
        fx = int'(x[9:0]);   fy = int'(y[9:0]);
        zx = (ex == 0);  zy = (ey == 0);
        ix = (ex == 31) && (fx == 0);  iy = (ey == 31) && (fy == 0);
        nx = (ex == 31) && (fx != 0);  ny = (ey == 31) && (fy != 0);
        if (nx || ny || (zx && zy) || (ix && iy)) return 16'h7E00;
        if (zy || ix) return {s, 15'h7C00};
        if (zx || iy) return {s, 15'h0000};
        ma = 1024 + fx;
        mb = 1024 + fy;
        e  = ex - ey + 15;
        if (ma >= mb) num = ma * 1024;
        else begin
            num = ma * 2048;
            e   = e - 1;
        end
        m = num / mb;
        r = num % mb;
        if ((2 * r > mb) || ((2 * r == mb) && (m % 2 == 1))) m = m + 1;
        if (m == 2048) begin
            m = 1024;
            e = e + 1;
        end
        if (e >= 31) return {s, 15'h7C00};
        if (e <= 0)  return {s, 15'h0000};
        return {s, 5'(e), 10'(m)};
    endfunction

    function automatic logic [15:0] rnd_op();
        logic [15:0] v;
        v = 16'($urandom);
        case ($urandom % 10)
            0: v[14:0] = 15'h0000;
            1: v[14:0] = 15'h7C00;
            2: v[14:10] = 5'h1F;
            3: v[14:10] = 5'h00;
            default: if (v[14:10] == 5'h1F || v[14:10] == 5'h00) v[14:10] = 5'(1 + $urandom % 30);
        endcase
        return v;
    endfunction

    // Consumer back-pressure
    initial begin
        out_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1 out_ready = hold_off ? 1'b0 : (($urandom % 4) != 0);
        end
    end

    // Monitor: latency, hold stability and result comparison
    always @(negedge clk) begin
        if (!rst && out_valid) begin
            if (!seen) begin
                seen = 1'b1;
                held = q;
                if (sb.size() == 0) check("unexpected_output", 32'd1, 32'd0);
                else                check("latency", 32'(cyc - sb[0].acc), 32'd16);
            end else begin
                check("hold_q", {16'd0, q}, {16'd0, held});
            end
            check("in_ready_busy", {31'd0, in_ready}, 32'd0);
            if (out_ready) begin
                if (sb.size() != 0) begin
                    exp_t e;
                    e = sb.pop_front();
                    check("q", {16'd0, q}, {16'd0, e.v});
                end
                seen = 1'b0;
            end
        end
    end

    task automatic send(input logic [15:0] x, input logic [15:0] y, input logic [15:0] ex);
        int n;
        exp_t e;
        @(negedge clk);
        in_valid = 1'b1;
        a = x;
        b = y;
        n = 0;
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            check("accept_timeout", 32'd1, 32'd0);
        end else begin
            e.v   = ex;
            e.acc = cyc + 1;
            sb.push_back(e);
            @(posedge clk);
        end
        #1 in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 400) begin
            @(negedge clk);
            n++;
        end
        check("drain", sb.size(), 32'd0);
    endtask

    initial begin
        int n;
        logic [15:0] x, y;
        rst = 1'b1;
        in_valid = 1'b0;
        a = 16'd0;
        b = 16'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_q", {16'd0, q}, 32'd0);
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        rst = 1'b0;

        send(16'h3C00, 16'h3C00, 16'h3C00);
        send(16'h3C00, 16'h4200, 16'h3555);
        send(16'h4600, 16'h4000, 16'h4200);
        send(16'hBC00, 16'h4000, 16'hB800);
        send(16'h3C00, 16'h0000, 16'h7C00);
        send(16'h0000, 16'h0000, 16'h7E00);
        send(16'h7C00, 16'h7C00, 16'h7E00);
        send(16'h7E01, 16'h3C00, 16'h7E00);
        send(16'h3C00, 16'h7C00, 16'h0000);
        send(16'h3C00, 16'h0001, 16'h7C00);
        send(16'h7BFF, 16'h2C00, 16'h7C00);
        send(16'h0400, 16'h7800, 16'h0000);
        drain();

        // Back-pressure hold, then abort by reset mid-division
        hold_off = 1'b1;
        send(16'h4600, 16'h4000, 16'h4200);
        n = 0;
        while (!out_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("hold_reach_valid", {31'd0, out_valid}, 32'd1);
        repeat (20) @(negedge clk);
        check("hold_still_valid", {31'd0, out_valid}, 32'd1);
        hold_off = 1'b0;
        drain();

        send(16'h3C00, 16'h3C00, 16'h3C00);
        repeat (5) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        check("abort_out_valid", {31'd0, out_valid}, 32'd0);
        check("abort_q", {16'd0, q}, 32'd0);
        check("abort_in_ready", {31'd0, in_ready}, 32'd1);
        sb.delete();
        seen = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_in_ready", {31'd0, in_ready}, 32'd1);
        send(16'h3C00, 16'h3C00, 16'h3C00);
        drain();

        for (int i = 0; i < 300; i++) begin
            x = rnd_op();
            y = rnd_op();
            send(x, y, model(x, y));
        end
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
